imem_loader_ctrl: RTL
=====================

// Module: imem_loader_ctrl
// PURPOSE
//  Parametrised front-end for the instruction memory on the dev board. Operator loads words from the DIP
//  switches and steps or auto-runs a program counter over the loaded region. Keys are synchronised,
//  debounced and edge-detected on clk, replacing key-as-clock counters. Drives memory port, LEDs, 7-seg.
// PARAMETERS
//  ADDR_W           8        memory address width; depth = 2**ADDR_W; must be <= 13
//  DATA_W           16       instruction word width (DIP/LED width)
//  DEBOUNCE_CYCLES  250000   consecutive stable clk cycles before a key level is accepted (>=2)
//  RUN_DIV          5000000  clk cycles per automatic pc step in run mode (>=1)
//  WRAP_PC          1        1: pc wraps to 0 past last loaded word; 0: pc holds there
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  dip        in   DATA_W  word to load
//  key        in   5       raw buttons, active-high: [0] load, [1] step, [2] clear eom, [3] clear pc, [4] display select
//  run        in   1       level; 1 = auto-step pc every RUN_DIV cycles
//  mem_addr   out  ADDR_W  memory address
//  mem_din    out  DATA_W  memory write data
//  mem_we     out  1       memory write enable, one-cycle pulse
//  mem_dout   in   DATA_W  memory read data, 1-cycle synchronous read latency
//  led        out  DATA_W  = mem_dout
//  sevenseg   out  13      zero-extended eom (key[4] debounced low) or pc (high)
//  full       out  1       memory fully loaded
// BEHAVIOUR
//  Reset (async, immediate): eom=0, pc=0, full=0, mem_we=0, mem_din=0, debounced levels=0, edge regs=0,
//   debounce and run counters=0. A write pending at reset is dropped.
//  Key path: 2-FF sync per key -> counter counts while sync != debounced level, clears when equal; at
//   DEBOUNCE_CYCLES-1 the level flips. Press = 1-cycle pulse on debounced rising edge. Release = no event.
//  Load (press0): if !full -> cycle N+1: mem_we=1, mem_addr=eom, mem_din=dip sampled at cycle N;
//   cycle N+2: eom+1. Write at address 2**ADDR_W-1 sets full, eom stays at 2**ADDR_W-1. Press0 while full ignored.
//  mem_addr = eom during the mem_we cycle, pc otherwise; led shows mem_dout one cycle after address change.
//  Word count loaded: cnt = full ? 2**ADDR_W : eom. Empty = (cnt==0).
//  Step (press1, run=0) or run tick (run=1): if empty pc holds 0; else if pc==cnt-1 -> pc=0 (WRAP_PC=1)
//   or hold (WRAP_PC=0); else pc+1. Press1 ignored while run=1.
//  Run counter: counts 0..RUN_DIV-1 while run=1, tick at RUN_DIV-1; cleared when run=0 or when pc cleared.
//  Clear eom (press2): eom=0, full=0; also pc=0 (pc must stay inside loaded region). Takes priority over
//   a simultaneous load (load dropped). Clear pc (press3): pc=0; priority over simultaneous step/tick.
//  Simultaneous load and step: both act; step uses cnt before the load's increment.
//  All arithmetic ADDR_W bits unsigned; no other overflow path (guarded by full / wrap rules).
// TESTING (bench uses DEBOUNCE_CYCLES=4, RUN_DIV=3, ADDR_W=3)
//  Bounce: key0 toggles 1,0,1 each 1 cycle then holds 1 -> exactly one mem_we pulse, eom 0->1.
//  Load 3 words 0xA001,0xA002,0xA003 -> writes at addr 0,1,2; sevenseg=3; full=0.
//  Load 8 words then press0 again -> 8 writes, full=1, eom=7, ninth press gives no mem_we.
//  With 3 words, press1 x4 -> pc 1,2,0,1 (WRAP_PC=1); with WRAP_PC=0 -> 1,2,2,2; led tracks word at pc.
//  run=1, 3 words -> pc advances every 3 cycles; press1 during run no effect; press3 -> pc=0, counter reset.
//  press0 and press2 same cycle -> no write, eom=0, pc=0; rst_n low mid-load -> mem_we never asserts.

Source files
------------

// File: rtl/imem_loader_ctrl.sv
// Instruction-memory loader front end: debounced keys load DIP words into consecutive addresses and
// step or auto-run a program counter over the loaded region; drives memory port, LEDs and 7-seg.
module imem_loader_ctrl #(
   parameter int ADDR_W          = 8,
   parameter int DATA_W          = 16,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int RUN_DIV         = 5000000,
   parameter bit WRAP_PC         = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] dip,
   input  logic [4:0]        key,
   input  logic              run,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_dout,
   output logic [DATA_W-1:0] led,
   output logic [12:0]       sevenseg,
   output logic              full
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam int RD_W = $clog2(RUN_DIV) + 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RD_W-1:0] RD_LAST = RD_W'(RUN_DIV - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

   // key synchroniser, debouncer and press detector
   logic [4:0]      sync1_q, sync2_q;
   logic [4:0]      deb_q, deb_d;
   logic [3:0]      deb_prev_q;
   logic [DB_W-1:0] db_cnt_q [5];
   logic [DB_W-1:0] db_cnt_d [5];
   logic [3:0]      press;

   // datapath state
   logic [ADDR_W-1:0] eom_q, eom_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              full_q, full_d;
   logic              mem_we_q, mem_we_d;
   logic [DATA_W-1:0] mem_din_q, mem_din_d;
   logic [RD_W-1:0]   run_cnt_q, run_cnt_d;

   logic [ADDR_W:0]   word_cnt;
   logic [ADDR_W:0]   last_pc;
   logic              empty;
   logic              pc_clr;
   logic              run_tick;
   logic              step_ev;

   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < 5; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               deb_d[i] = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign press = deb_q[3:0] & ~deb_prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_q      <= '0;
         deb_prev_q <= '0;
         for (int i = 0; i < 5; i++) begin
            db_cnt_q[i] <= '0;
         end
      end else begin
         sync1_q    <= key;
         sync2_q    <= sync1_q;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q[3:0];
         for (int i = 0; i < 5; i++) begin
            db_cnt_q[i] <= db_cnt_d[i];
         end
      end
   end

   // A full memory holds 2**ADDR_W words, one more than eom can express.
   assign word_cnt = full_q ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, eom_q};
   assign last_pc  = word_cnt - 1'b1;
   assign empty    = (word_cnt == '0);
   assign pc_clr   = press[2] | press[3];
   assign run_tick = run && (run_cnt_q == RD_LAST);
   assign step_ev  = run ? run_tick : press[1];

   always_comb begin
      run_cnt_d = run_cnt_q + 1'b1;
      if (!run || pc_clr || run_tick) begin
         run_cnt_d = '0;
      end
   end

   always_comb begin
      pc_d = pc_q;
      if (pc_clr) begin
         pc_d = '0;
      end else if (step_ev) begin
         if (empty) begin
            pc_d = '0;
         end else if ({1'b0, pc_q} == last_pc) begin
            pc_d = WRAP_PC ? '0 : pc_q;
         end else begin
            pc_d = pc_q + 1'b1;
         end
      end
   end

   // Clearing eom drops a load pressed in the same cycle.
   always_comb begin
      mem_we_d  = press[0] & ~press[2] & ~full_q;
      mem_din_d = mem_we_d ? dip : mem_din_q;
      eom_d     = eom_q;
      full_d    = full_q;
      if (mem_we_q) begin
         if (eom_q == ADDR_LAST) begin
            full_d = 1'b1;
         end else begin
            eom_d = eom_q + 1'b1;
         end
      end
      if (press[2]) begin
         eom_d  = '0;
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eom_q     <= '0;
         pc_q      <= '0;
         full_q    <= 1'b0;
         mem_we_q  <= 1'b0;
         mem_din_q <= '0;
         run_cnt_q <= '0;
      end else begin
         eom_q     <= eom_d;
         pc_q      <= pc_d;
         full_q    <= full_d;
         mem_we_q  <= mem_we_d;
         mem_din_q <= mem_din_d;
         run_cnt_q <= run_cnt_d;
      end
   end

   assign mem_addr = mem_we_q ? eom_q : pc_q;
   assign mem_we   = mem_we_q;
   assign mem_din  = mem_din_q;
   assign led      = mem_dout;
   assign sevenseg = deb_q[4] ? 13'(pc_q) : 13'(eom_q);
   assign full     = full_q;

endmodule
